// File: rtl/edge_event_arbiter_pkg.sv
// Shared types, edge encodings and the round-robin helper for edge_event_arbiter.
package edge_event_arbiter_pkg;

  // Edge selection encodings for the EDGE parameter.
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_BOTH = 2;

  // Widest supported line count; the arbiter helper works on this fixed width.
  localparam int MAX_LINES = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  // First set request at or above start, wrapping at n. Returns n when req is empty.
  function automatic int rr_pick(input logic [MAX_LINES-1:0] req, input int start, input int n);
    int cand;
    rr_pick = n;
    // Walk from the far end so the closest candidate to start is written last.
    for (int k = MAX_LINES - 1; k >= 0; k--) begin
      if (k < n) begin
        cand = start + k;
        if (cand >= n) begin
          cand = cand - n;
        end
        if (req[cand[2:0]]) begin
          rr_pick = cand;
        end
      end
    end
  endfunction

endpackage

// File: rtl/edge_event_arbiter_edge_cell.sv
// Per-line two-stage sampler and edge detector.
module edge_cell
  import edge_event_arbiter_pkg::*;
#(
  parameter int unsigned EDGE = EDGE_RISE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_din,
  output logic o_edge
);

  logic r_q;
  logic r_qq;

  // Sample chain: r_q is din one clock late, r_qq two clocks late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q  <= 1'b0;
      r_qq <= 1'b0;
    end else begin
      r_q  <= i_din;
      r_qq <= r_q;
    end
  end

  // Edge qualifier, fixed at elaboration by EDGE.
  always_comb begin
    if (EDGE == EDGE_FALL) begin
      o_edge = ~r_q & r_qq;
    end else if (EDGE == EDGE_BOTH) begin
      o_edge = r_q ^ r_qq;
    end else begin
      o_edge = r_q & ~r_qq;
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: latches per-line edges as pending events and offers them
// one at a time, round-robin, over a valid/ready handshake.
module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned EDGE = EDGE_RISE,
  parameter int unsigned IDW  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   din,
  output logic           ev_valid,
  output logic [IDW-1:0] ev_id,
  input  logic           ev_ready,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overrun,
  input  logic           clr_overrun
);

  logic [N-1:0]         w_edge;
  logic [N-1:0]         w_clr;
  logic [N-1:0]         w_ov_set;
  logic [N-1:0]         w_pending_d;
  logic [N-1:0]         w_overrun_d;
  logic [N-1:0]         r_pending;
  logic [N-1:0]         r_overrun;
  logic [MAX_LINES-1:0] w_req;
  logic                 w_hs;
  int                   w_win;
  arb_state_e           r_state;
  arb_state_e           w_state_d;
  logic [IDW-1:0]       r_ev_id;
  logic [IDW-1:0]       w_ev_id_d;
  logic [IDW-1:0]       r_rr;
  logic [IDW-1:0]       w_rr_d;

  for (genvar g = 0; g < N; g++) begin : g_cell
    edge_cell #(
      .EDGE (EDGE)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_din  (din[g]),
      .o_edge (w_edge[g])
    );
  end

  assign w_hs  = (r_state == OFFER) && ev_ready;
  assign w_req = MAX_LINES'(r_pending);
  assign w_win = rr_pick(w_req, int'(r_rr), int'(N));

  // Pending/overrun next state; a clear of the offered line lets a same-cycle edge re-arm it.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_clr[i] = w_hs && (r_ev_id == IDW'(i));
    end
    w_ov_set    = w_edge & r_pending & ~w_clr;
    w_pending_d = (r_pending & ~w_clr) | w_edge;
    // Set beats clear so an overrun coinciding with clr_overrun is not lost.
    w_overrun_d = (clr_overrun ? '0 : r_overrun) | w_ov_set;
  end

  // Event bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= w_pending_d;
      r_overrun <= w_overrun_d;
    end
  end

  // Arbiter FSM next state: pick a winner in IDLE, hold it stable through OFFER.
  always_comb begin
    w_state_d = r_state;
    w_ev_id_d = r_ev_id;
    w_rr_d    = r_rr;
    unique case (r_state)
      IDLE: begin
        if (|r_pending) begin
          w_ev_id_d = IDW'(w_win);
          w_state_d = OFFER;
        end
      end
      OFFER: begin
        if (ev_ready) begin
          w_state_d = IDLE;
          w_rr_d    = (r_ev_id == IDW'(N - 1)) ? '0 : r_ev_id + 1'b1;
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  // Arbiter FSM state, offered id and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ev_id <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_d;
      r_ev_id <= w_ev_id_d;
      r_rr    <= w_rr_d;
    end
  end

  assign ev_valid = (r_state == OFFER);
  assign ev_id    = r_ev_id;
  assign pending  = r_pending;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed table, corner sequences and random traffic
// checked against a behavioural model of the arbitration rules.
module tb_edge_event_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   din;
  logic           ev_ready;
  logic           clr_overrun;
  logic           ev_valid;
  logic [IDW-1:0] ev_id;
  logic [N-1:0]   pending;
  logic [N-1:0]   overrun;

  logic [N-1:0]   din_b;
  logic           ready_b;
  logic           clr_b;
  logic           valid_b;
  logic [IDW-1:0] id_b;
  logic [N-1:0]   pend_b;
  logic [N-1:0]   ovr_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  edge_event_arbiter #(.N(N), .EDGE(0), .IDW(IDW)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .ev_valid    (ev_valid),
    .ev_id       (ev_id),
    .ev_ready    (ev_ready),
    .pending     (pending),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  edge_event_arbiter #(.N(N), .EDGE(2), .IDW(IDW)) u_both (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din_b),
    .ev_valid    (valid_b),
    .ev_id       (id_b),
    .ev_ready    (ready_b),
    .pending     (pend_b),
    .overrun     (ovr_b),
    .clr_overrun (clr_b)
  );

  // Reference model (rising-edge instance): per-line sample history and event sets.
  int m_q[N];
  int m_qq[N];
  int m_pend[N];
  int m_ovr[N];
  int m_rr;
  int m_offer;  // line currently offered, -1 when nothing is offered
  int m_id;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_q[i] = 0; m_qq[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
    end
    m_rr = 0; m_offer = -1; m_id = 0;
  endfunction

  function automatic void model_clock();
    int e[N];
    int np[N];
    int no[N];
    int keep;
    int served;
    int c;
    served = (m_offer >= 0 && ev_ready === 1'b1) ? m_offer : -1;
    for (int i = 0; i < N; i++) begin
      e[i]  = (m_q[i] == 1 && m_qq[i] == 0) ? 1 : 0;
      keep  = (m_pend[i] == 1 && i != served) ? 1 : 0;
      np[i] = (keep == 1 || e[i] == 1) ? 1 : 0;
      no[i] = ((clr_overrun !== 1'b1 && m_ovr[i] == 1) || (keep == 1 && e[i] == 1)) ? 1 : 0;
    end
    if (m_offer < 0) begin
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (m_offer < 0 && m_pend[c] == 1) begin
          m_offer = c;
          m_id    = c;
        end
      end
    end else if (served >= 0) begin
      m_rr    = (served + 1) % N;
      m_offer = -1;
    end
    for (int i = 0; i < N; i++) begin
      m_qq[i]   = m_q[i];
      m_q[i]    = din[i] ? 1 : 0;
      m_pend[i] = np[i];
      m_ovr[i]  = no[i];
    end
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_pack();
    return {5'd0, ev_valid, (ev_valid ? ev_id : 2'd0), pending, overrun};
  endfunction

  function automatic logic [15:0] model_pack();
    logic [N-1:0] ep;
    logic [N-1:0] eo;
    for (int i = 0; i < N; i++) begin
      ep[i] = (m_pend[i] == 1);
      eo[i] = (m_ovr[i] == 1);
    end
    return {5'd0, (m_offer >= 0), (m_offer >= 0 ? 2'(m_id) : 2'd0), ep, eo};
  endfunction

  // One clock: advance DUT and model, then compare at the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    @(negedge clk);
    chk(tag, dut_pack(), model_pack());
  endtask

  task automatic do_reset(input logic [N-1:0] din_hold);
    @(negedge clk);
    rst_n = 1'b0; din = din_hold; ev_ready = 1'b0; clr_overrun = 1'b0; din_b = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]   din;
    logic           rdy;
    logic           clr;
    logic           ev;
    logic [IDW-1:0] id;
    logic [N-1:0]   pend;
    logic [N-1:0]   ovr;
  } vec_t;

  vec_t tbl[13];

  int ids[$];
  int cyc[$];
  int n_b;
  int n_b3;

  initial begin
    rst_n = 1'b0; din = '0; ev_ready = 1'b0; clr_overrun = 1'b0;
    din_b = '0; ready_b = 1'b1; clr_b = 1'b0;
    model_reset();

    // din[2] rise served, then din[1] double pulse with ready low, clear, serve.
    tbl[0]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0100, 4'b0000};
    tbl[2]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000};
    tbl[3]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b0110, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0010, 4'b0000};
    tbl[7]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000};
    tbl[8]  = '{4'b0110, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000};
    tbl[9]  = '{4'b0110, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0010};
    tbl[10] = '{4'b0110, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 4'b0000};
    tbl[11] = '{4'b0110, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
    tbl[12] = '{4'b0110, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};

    do_reset('0);
    chk("reset_state", dut_pack(), 16'h0000);

    for (int r = 0; r < 13; r++) begin
      din = tbl[r].din; ev_ready = tbl[r].rdy; clr_overrun = tbl[r].clr;
      @(posedge clk);
      model_clock();
      @(negedge clk);
      chk($sformatf("vec%0d", r), dut_pack(),
          {5'd0, tbl[r].ev, tbl[r].id, tbl[r].pend, tbl[r].ovr});
    end

    // Simultaneous rises on 0, 1, 3 from rr=0: offers 0, 1, 3 two cycles apart.
    do_reset('0);
    ev_ready = 1'b1; din = 4'b1011;
    for (int c = 0; c < 12; c++) begin
      step("rr_burst");
      if (ev_valid) begin
        ids.push_back(int'(ev_id));
        cyc.push_back(c);
      end
    end
    chk("rr_burst_count", 16'(ids.size()), 16'd3);
    if (ids.size() == 3) begin
      chk("rr_burst_id0", 16'(ids[0]), 16'd0);
      chk("rr_burst_id1", 16'(ids[1]), 16'd1);
      chk("rr_burst_id2", 16'(ids[2]), 16'd3);
      chk("rr_burst_gap1", 16'(cyc[1] - cyc[0]), 16'd2);
      chk("rr_burst_gap2", 16'(cyc[2] - cyc[1]), 16'd2);
    end

    // New edge on the offered line exactly on the handshake cycle.
    do_reset('0);
    din = 4'b0001;
    for (int c = 0; c < 4; c++) step("hs_edge_setup");
    chk("hs_edge_offer", {15'd0, ev_valid}, 16'd1);
    din = 4'b0000;
    step("hs_edge_low");
    step("hs_edge_low");
    din = 4'b0001;
    step("hs_edge_rise");
    ev_ready = 1'b1;
    step("hs_edge_hs");
    chk("hs_edge_pend_kept", {12'd0, pending}, 16'h0001);
    chk("hs_edge_no_ovr", {12'd0, overrun}, 16'h0000);
    ev_ready = 1'b0;
    step("hs_edge_reoffer");
    chk("hs_edge_reoffer_id", {14'd0, ev_valid, ev_id == 2'd0}, 16'd3);

    // Serve line 0 (rr -> 1), offer line 1, then reset mid-offer.
    ev_ready = 1'b1;
    step("rst_pre_serve");
    ev_ready = 1'b0; din = 4'b0011;
    for (int c = 0; c < 3; c++) step("rst_pre_offer");
    chk("rst_pre_offer_id", {14'd0, ev_valid, ev_id == 2'd1}, 16'd3);
    rst_n = 1'b0; din = '0;
    model_reset();
    #1;
    chk("rst_async_valid", {15'd0, ev_valid}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_after_state", dut_pack(), 16'h0000);
    din = 4'b1001; ev_ready = 1'b1;
    step("rst_rr");
    step("rst_rr");
    step("rst_rr");
    chk("rst_rr_first_id", {14'd0, ev_valid, ev_id == 2'd0}, 16'd3);
    for (int c = 0; c < 4; c++) step("rst_rr_tail");

    // Lines held high across reset release are seen as rising edges.
    do_reset(4'b1111);
    step("rel_high");
    chk("rel_high_c1", {12'd0, pending}, 16'h0000);
    step("rel_high");
    chk("rel_high_c2", {12'd0, pending}, 16'h000f);

    // Both-edge instance: one pulse on line 3 yields two events, no overrun.
    do_reset('0);
    ready_b = 1'b1;
    n_b = 0; n_b3 = 0;
    for (int c = 0; c < 18; c++) begin
      if (c == 2) din_b = 4'b1000;
      if (c == 5) din_b = 4'b0000;
      step("both_main");
      if (valid_b) begin
        n_b++;
        if (id_b == 2'd3) n_b3++;
      end
    end
    chk("both_events_total", 16'(n_b), 16'd2);
    chk("both_events_line3", 16'(n_b3), 16'd2);
    chk("both_no_ovr", {12'd0, ovr_b}, 16'h0000);
    chk("both_idle_pend", {12'd0, pend_b}, 16'h0000);

    // Random traffic against the model, with occasional resets.
    do_reset('0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(N'($urandom));
      end
      if ($urandom_range(0, 2) == 0) din = N'($urandom);
      ev_ready    = ($urandom_range(0, 3) != 0);
      clr_overrun = ($urandom_range(0, 7) == 0);
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
